data_uncache_bridge: RTL and testbench

//   Data-side bridge behind the address translation unit. Takes the CPU's physical data request
//   and the translator's no_dcache flag, then steers it:
//   - cached (kseg0/kuseg) requests go to the D-cache port;
//   - uncached (kseg1, MMIO) requests go to a single-beat uncached SRAM-like bus.

---
 rtl/data_uncache_bridge_pkg.sv | 13 +
 rtl/data_uncache_bridge_size_to_wstrb.sv | 25 ++
 rtl/data_uncache_bridge.sv | 127 ++++++++++++
 tb/tb_data_uncache_bridge.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_uncache_bridge_pkg.sv
// Shared CPU-side definitions: access size encodings and the data bridge state encoding.
package data_uncache_bridge_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_C_WAIT = 2'b01;
  localparam logic [1:0] ST_U_ADDR = 2'b10;
  localparam logic [1:0] ST_U_DATA = 2'b11;

endpackage

// File: rtl/data_uncache_bridge_size_to_wstrb.sv
// Byte-enable generator for single-beat uncached accesses; pure combinational.
module size_to_wstrb
  import data_uncache_bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       wr,
  output logic [3:0] wstrb
);

  // Loads never enable lanes; the reserved size encoding behaves as a word access.
  always_comb begin
    wstrb = 4'b0000;
    if (!wr) begin
      wstrb = 4'b0000;
    end else begin
      case (size)
        SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
        SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        default:   wstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/data_uncache_bridge.sv
// Data-side bridge: steers translated CPU requests to the D-cache or to a single-beat
// uncached bus, one transaction outstanding, responses returned in order.
module data_uncache_bridge
  import data_uncache_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_paddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_no_dcache,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dc_req,
  output logic              dc_wr,
  output logic [1:0]        dc_size,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_addr_ok,
  input  logic              dc_data_ok,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              uc_req,
  output logic              uc_wr,
  output logic [1:0]        uc_size,
  output logic [ADDR_W-1:0] uc_addr,
  output logic [DATA_W-1:0] uc_wdata,
  output logic [3:0]        uc_wstrb,
  input  logic              uc_addr_ok,
  input  logic              uc_data_ok,
  input  logic [DATA_W-1:0] uc_rdata
);

  logic [1:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic idle_s, c_wait_s, u_addr_s, u_data_s, dc_sel_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign c_wait_s = (state_q == ST_C_WAIT);
  assign u_addr_s = (state_q == ST_U_ADDR);
  assign u_data_s = (state_q == ST_U_DATA);
  assign dc_sel_s = idle_s & ~cpu_no_dcache;

  // Next-state and capture logic; cpu_no_dcache only matters while an IDLE request is pending.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    paddr_d = paddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_no_dcache) begin
            wr_d    = cpu_wr;
            size_d  = cpu_size;
            paddr_d = cpu_paddr;
            wdata_d = cpu_wdata;
            state_d = ST_U_ADDR;
          end else if (dc_addr_ok) begin
            state_d = ST_C_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_C_WAIT: state_d = dc_data_ok ? ST_IDLE : ST_C_WAIT;
      ST_U_ADDR: state_d = uc_addr_ok ? ST_U_DATA : ST_U_ADDR;
      ST_U_DATA: state_d = uc_data_ok ? ST_IDLE : ST_U_DATA;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state and uncached capture registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      paddr_q <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      paddr_q <= paddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign cpu_addr_ok = idle_s & cpu_req & (cpu_no_dcache | dc_addr_ok);
  assign cpu_data_ok = (c_wait_s & dc_data_ok) | (u_data_s & uc_data_ok);
  assign cpu_rdata   = c_wait_s ? dc_rdata :
                       u_data_s ? uc_rdata : {DATA_W{1'b0}};

  // The cached path is a pass-through while idle and quiet everywhere else.
  assign dc_req   = dc_sel_s & cpu_req;
  assign dc_wr    = dc_sel_s & cpu_wr;
  assign dc_size  = dc_sel_s ? cpu_size  : 2'b00;
  assign dc_addr  = dc_sel_s ? cpu_paddr : {ADDR_W{1'b0}};
  assign dc_wdata = dc_sel_s ? cpu_wdata : {DATA_W{1'b0}};

  assign uc_req   = u_addr_s;
  assign uc_wr    = wr_q;
  assign uc_size  = size_q;
  assign uc_addr  = paddr_q;
  assign uc_wdata = wdata_q;

  size_to_wstrb u_wstrb (
    .size    (size_q),
    .addr_lo (paddr_q[1:0]),
    .wr      (wr_q),
    .wstrb   (uc_wstrb)
  );

endmodule

// File: tb/tb_data_uncache_bridge.sv
// Directed bench for data_uncache_bridge: stimulus pushes expected responses into a
// scoreboard, a negedge monitor pops and compares them on every cpu_data_ok.
module tb_data_uncache_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr, cpu_no_dcache;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_paddr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        dc_req, dc_wr;
  logic [1:0]  dc_size;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        uc_req, uc_wr;
  logic [1:0]  uc_size;
  logic [31:0] uc_addr, uc_wdata;
  logic [3:0]  uc_wstrb;
  logic        uc_addr_ok, uc_data_ok;
  logic [31:0] uc_rdata;

  int total  = 0;
  int passed = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_e;

  always #5 clk = ~clk;

  data_uncache_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_paddr(cpu_paddr),
    .cpu_wdata(cpu_wdata), .cpu_no_dcache(cpu_no_dcache),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .uc_req(uc_req), .uc_wr(uc_wr), .uc_size(uc_size), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_wstrb(uc_wstrb), .uc_addr_ok(uc_addr_ok), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_data_ok === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_data_ok", {31'd0, cpu_data_ok}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e[32]) chk("sb_rdata", cpu_rdata, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_cpu(input logic req, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic nd);
    cpu_req = req; cpu_wr = wr; cpu_size = size;
    cpu_paddr = addr; cpu_wdata = wdata; cpu_no_dcache = nd;
  endtask

  task automatic quiet_slaves();
    dc_addr_ok = 1'b0; dc_data_ok = 1'b0; dc_rdata = 32'h0;
    uc_addr_ok = 1'b0; uc_data_ok = 1'b0; uc_rdata = 32'h0;
  endtask

  task automatic uc_store(input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [3:0] strb);
    drive_cpu(1'b1, 1'b1, size, addr, wdata, 1'b1);
    smp();
    chk("us_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    chk("us_dc_req", {31'd0, dc_req}, 32'd0);
    if (cpu_addr_ok) sb_q.push_back({1'b0, 32'h0});
    tick();
    cpu_req = 1'b0; uc_addr_ok = 1'b1;
    smp();
    chk("us_uc_req", {31'd0, uc_req}, 32'd1);
    chk("us_uc_addr", uc_addr, addr);
    chk("us_uc_wdata", uc_wdata, wdata);
    chk("us_uc_wr", {31'd0, uc_wr}, 32'd1);
    chk("us_uc_wstrb", {28'd0, uc_wstrb}, {28'd0, strb});
    tick();
    uc_addr_ok = 1'b0; uc_data_ok = 1'b1;
    smp();
    chk("us_uc_req_drop", {31'd0, uc_req}, 32'd0);
    chk("us_data_ok", {31'd0, cpu_data_ok}, 32'd1);
    tick();
    uc_data_ok = 1'b0;
  endtask

  logic [31:0] st_addr[4]  = '{32'h1FAF_F003, 32'h1FF0_0000, 32'h1FF0_0002, 32'h1FF0_0001};
  logic [1:0]  st_size[4]  = '{2'b00, 2'b01, 2'b01, 2'b00};
  logic [3:0]  st_strb[4]  = '{4'b1000, 4'b0011, 4'b1100, 4'b0010};

  initial begin
    resetn = 1'b0;
    drive_cpu(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    quiet_slaves();
    tick(); tick();
    smp();
    chk("rst_addr_ok", {31'd0, cpu_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("rst_uc_req", {31'd0, uc_req}, 32'd0);
    chk("rst_dc_req", {31'd0, dc_req}, 32'd0);
    chk("rst_uc_addr", uc_addr, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // 1: cached load, data three cycles after acceptance
    drive_cpu(1'b1, 1'b0, 2'b10, 32'h8000_0010, 32'h0, 1'b0);
    dc_addr_ok = 1'b1;
    smp();
    chk("t1_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    chk("t1_dc_req", {31'd0, dc_req}, 32'd1);
    chk("t1_dc_addr", dc_addr, 32'h8000_0010);
    chk("t1_uc_req", {31'd0, uc_req}, 32'd0);
    if (cpu_addr_ok) sb_q.push_back({1'b1, 32'hDEAD_BEEF});
    tick();
    cpu_req = 1'b0; dc_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t1_early_data_ok", {31'd0, cpu_data_ok}, 32'd0);
      chk("t1_wait_dc_req", {31'd0, dc_req}, 32'd0);
      chk("t1_wait_uc_req", {31'd0, uc_req}, 32'd0);
      tick();
    end
    dc_data_ok = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1_data_ok", {31'd0, cpu_data_ok}, 32'd1);
    chk("t1_uc_req_end", {31'd0, uc_req}, 32'd0);
    tick();
    dc_data_ok = 1'b0;
    smp();
    chk("t1_single_pulse", {31'd0, cpu_data_ok}, 32'd0);
    chk("t1_idle_rdata", cpu_rdata, 32'h0);
    tick();

    // 2 and strobe table: uncached stores of various sizes/offsets
    for (int i = 0; i < 4; i++) uc_store(st_addr[i], st_size[i], 32'hAA00_0000, st_strb[i]);
    uc_store(32'h1FF0_0008, 2'b11, 32'h5566_7788, 4'b1111);

    // 3: uncached half load with uc_addr_ok stalled four cycles
    drive_cpu(1'b1, 1'b0, 2'b01, 32'h1FC0_0002, 32'h0, 1'b1);
    smp();
    chk("t3_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    if (cpu_addr_ok) sb_q.push_back({1'b1, 32'h1234_5678});
    tick();
    drive_cpu(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t3_uc_req", {31'd0, uc_req}, 32'd1);
      chk("t3_uc_addr", uc_addr, 32'h1FC0_0002);
      chk("t3_uc_size", {30'd0, uc_size}, 32'd1);
      chk("t3_uc_wr", {31'd0, uc_wr}, 32'd0);
      chk("t3_uc_wstrb", {28'd0, uc_wstrb}, 32'd0);
      tick();
    end
    uc_addr_ok = 1'b1;
    smp();
    chk("t3_uc_req_hs", {31'd0, uc_req}, 32'd1);
    tick();
    uc_addr_ok = 1'b0;
    smp();
    chk("t3_uc_req_drop", {31'd0, uc_req}, 32'd0);
    chk("t3_no_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    tick();
    uc_data_ok = 1'b1; uc_rdata = 32'h1234_5678;
    smp();
    chk("t3_rdata", cpu_rdata, 32'h1234_5678);
    tick();
    uc_data_ok = 1'b0;

    // 4: cached request held behind an uncached one
    drive_cpu(1'b1, 1'b0, 2'b10, 32'h1FD0_0000, 32'h0, 1'b1);
    smp();
    chk("t4_u_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    if (cpu_addr_ok) sb_q.push_back({1'b1, 32'hCAFE_F00D});
    tick();
    drive_cpu(1'b1, 1'b0, 2'b10, 32'h8000_0020, 32'h0, 1'b0);
    dc_addr_ok = 1'b1; uc_addr_ok = 1'b1;
    smp();
    chk("t4_hold_addr_ok0", {31'd0, cpu_addr_ok}, 32'd0);
    chk("t4_hold_dc_req0", {31'd0, dc_req}, 32'd0);
    tick();
    uc_addr_ok = 1'b0; uc_data_ok = 1'b1; uc_rdata = 32'hCAFE_F00D;
    smp();
    chk("t4_hold_addr_ok1", {31'd0, cpu_addr_ok}, 32'd0);
    chk("t4_u_data_ok", {31'd0, cpu_data_ok}, 32'd1);
    tick();
    uc_data_ok = 1'b0;
    smp();
    chk("t4_c_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    if (cpu_addr_ok) sb_q.push_back({1'b1, 32'h0BAD_C0DE});
    tick();
    cpu_req = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b1; dc_rdata = 32'h0BAD_C0DE;
    smp();
    chk("t4_c_data_ok", {31'd0, cpu_data_ok}, 32'd1);
    tick();
    dc_data_ok = 1'b0;

    // 5: reset while waiting in U_DATA, then a stale uc_data_ok
    drive_cpu(1'b1, 1'b1, 2'b10, 32'h1FC0_0100, 32'h7777_7777, 1'b1);
    smp();
    if (cpu_addr_ok) sb_q.push_back({1'b0, 32'h0});
    tick();
    cpu_req = 1'b0; uc_addr_ok = 1'b1;
    tick();
    uc_addr_ok = 1'b0;
    smp();
    chk("t5_in_u_data", {31'd0, uc_req}, 32'd0);
    #1;
    resetn = 1'b0;
    sb_q.delete();
    tick();
    smp();
    chk("t5_rst_uc_req", {31'd0, uc_req}, 32'd0);
    chk("t5_rst_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("t5_rst_uc_addr", uc_addr, 32'h0);
    chk("t5_rst_uc_wstrb", {28'd0, uc_wstrb}, 32'd0);
    chk("t5_rst_dc_req", {31'd0, dc_req}, 32'd0);
    tick();
    resetn = 1'b1; uc_data_ok = 1'b1; uc_rdata = 32'h5A5A_5A5A;
    smp();
    chk("t5_late_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("t5_late_rdata", cpu_rdata, 32'h0);
    tick();
    uc_data_ok = 1'b0;

    // 6: held cached request re-steered to the uncached bus
    drive_cpu(1'b1, 1'b1, 2'b10, 32'h1FE0_0004, 32'h1122_3344, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("t6_dc_req", {31'd0, dc_req}, 32'd1);
      chk("t6_wait_addr_ok", {31'd0, cpu_addr_ok}, 32'd0);
      tick();
    end
    cpu_no_dcache = 1'b1;
    smp();
    chk("t6_dc_req_drop", {31'd0, dc_req}, 32'd0);
    chk("t6_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    if (cpu_addr_ok) sb_q.push_back({1'b0, 32'h0});
    tick();
    cpu_req = 1'b0; uc_addr_ok = 1'b1;
    smp();
    chk("t6_uc_req", {31'd0, uc_req}, 32'd1);
    chk("t6_uc_addr", uc_addr, 32'h1FE0_0004);
    chk("t6_uc_wstrb", {28'd0, uc_wstrb}, 32'hF);
    tick();
    uc_addr_ok = 1'b0; uc_data_ok = 1'b1;
    smp();
    chk("t6_data_ok", {31'd0, cpu_data_ok}, 32'd1);
    tick();
    uc_data_ok = 1'b0;

    smp();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
